// File: rtl/board_scroll_ctrl.sv
// board_scroll_ctrl: 4x8 falling-tile board sequencer with LFSR spawning,
// key hit resolution on the bottom row, saturating score and game-over detection.
module board_scroll_ctrl #(
  parameter int         TICK_DIV   = 25_000_000,
  parameter logic [2:0] TILE_COLOR = 3'b001,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic        CLK_50M,
  input  logic        RST_N,
  input  logic        start,
  input  logic [3:0]  key,
  output logic [23:0] column_0,
  output logic [23:0] column_1,
  output logic [23:0] column_2,
  output logic [23:0] column_3,
  output logic [7:0]  score,
  output logic        running,
  output logic        game_over,
  output logic        row_tick
);
  localparam int CW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
  state_t        r_state, w_state;
  logic [23:0]   r_col [4];
  logic [23:0]   w_col [4];
  logic [23:0]   w_clr [4];
  logic [7:0]    r_score, w_score, r_lfsr;
  logic [CW-1:0] r_tick, w_tick;
  logic [3:0]    r_key_q, w_edge, w_bot, w_hit;
  logic [2:0]    w_nhits;
  logic [8:0]    w_sum;
  logic          w_wrong, w_scroll, w_miss, w_row_tick;
  logic          r_row_tick, r_running, r_game_over;
  assign w_edge   = key & ~r_key_q;
  assign w_hit    = w_edge & w_bot;
  assign w_wrong  = |(w_edge & ~w_bot);
  assign w_scroll = (r_state == RUN) && (r_tick == CW'(TICK_DIV - 1));
  assign w_nhits  = {2'b0, w_hit[0]} + {2'b0, w_hit[1]} + {2'b0, w_hit[2]} + {2'b0, w_hit[3]};
  assign w_sum    = {1'b0, r_score} + {6'b0, w_nhits};
  // Hits are cleared before the miss test so a key on the scroll cycle saves its tile.
  always_comb begin
    w_bot  = '0;
    w_miss = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_bot[i] = |r_col[i][2:0];
      w_clr[i] = w_hit[i] ? {r_col[i][23:3], 3'b000} : r_col[i];
      w_miss   = w_miss | (|w_clr[i][2:0]);
    end
  end
  always_comb begin
    w_state    = r_state;
    w_col      = r_col;
    w_score    = r_score;
    w_tick     = r_tick;
    w_row_tick = 1'b0;
    case (r_state)
      IDLE: begin
        w_tick = '0;
        for (int i = 0; i < 4; i++) w_col[i] = '0;
        if (start) begin
          w_state = RUN;
          w_score = '0;
        end
      end
      RUN: begin
        if (w_wrong) w_state = OVER;
        else begin
          w_col   = w_clr;
          w_score = w_sum[8] ? 8'hFF : w_sum[7:0];
          if (!w_scroll) w_tick = r_tick + CW'(1);
          else if (w_miss) w_state = OVER;
          else begin
            for (int i = 0; i < 4; i++)
              w_col[i] = {(r_lfsr[1:0] == 2'(i)) ? TILE_COLOR : 3'b000, w_clr[i][23:3]};
            w_tick     = '0;
            w_row_tick = 1'b1;
          end
        end
      end
      OVER: begin
        if (start) begin
          w_state = RUN;
          w_score = '0;
          w_tick  = '0;
          for (int i = 0; i < 4; i++) w_col[i] = '0;
        end
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      for (int i = 0; i < 4; i++) r_col[i] <= '0;
      r_score     <= '0;
      r_tick      <= '0;
      r_key_q     <= '0;
      r_lfsr      <= LFSR_SEED;
      r_row_tick  <= 1'b0;
      r_running   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_col       <= w_col;
      r_score     <= w_score;
      r_tick      <= w_tick;
      r_key_q     <= key;
      r_lfsr      <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      r_row_tick  <= w_row_tick;
      r_running   <= w_state == RUN;
      r_game_over <= w_state == OVER;
    end
  end
  assign column_0  = r_col[0];
  assign column_1  = r_col[1];
  assign column_2  = r_col[2];
  assign column_3  = r_col[3];
  assign score     = r_score;
  assign running   = r_running;
  assign game_over = r_game_over;
  assign row_tick  = r_row_tick;
endmodule
